// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin payout sequencer driving quarter/dime/nickel eject solenoids
module change_dispenser #(
  parameter int AMT_W        = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amount,
  output logic             change_ready,
  output logic             eject_25,
  output logic             eject_10,
  output logic             eject_5,
  output logic             busy,
  output logic             done,
  output logic             short_pay,
  output logic [AMT_W-1:0] coins_paid
);

  // Counter only ever needs to hold (max timing length - 1).
  localparam int MAX_C = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [AMT_W-1:0] COIN_25 = AMT_W'(25);
  localparam logic [AMT_W-1:0] COIN_10 = AMT_W'(10);
  localparam logic [AMT_W-1:0] COIN_5  = AMT_W'(5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state;
  logic [AMT_W-1:0] remaining;
  logic [CNT_W-1:0] cnt;

  // Payout FSM; every output is a register so solenoid drives never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      remaining    <= '0;
      cnt          <= '0;
      change_ready <= 1'b1;
      eject_25     <= 1'b0;
      eject_10     <= 1'b0;
      eject_5      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      short_pay    <= 1'b0;
      coins_paid   <= '0;
    end else begin
      // done/short_pay are single-cycle strobes tied to the DONE state.
      done      <= 1'b0;
      short_pay <= 1'b0;
      case (state)
        S_IDLE: begin
          if (change_valid && change_ready) begin
            remaining    <= change_amount;
            coins_paid   <= '0;
            change_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= S_SELECT;
          end
        end
        S_SELECT: begin
          // Compare before subtract, so remaining can never wrap.
          if (remaining >= COIN_25) begin
            remaining  <= remaining - COIN_25;
            eject_25   <= 1'b1;
            coins_paid <= coins_paid + AMT_W'(1);
            cnt        <= PULSE_LOAD;
            state      <= S_PULSE;
          end else if (remaining >= COIN_10) begin
            remaining  <= remaining - COIN_10;
            eject_10   <= 1'b1;
            coins_paid <= coins_paid + AMT_W'(1);
            cnt        <= PULSE_LOAD;
            state      <= S_PULSE;
          end else if (remaining >= COIN_5) begin
            remaining  <= remaining - COIN_5;
            eject_5    <= 1'b1;
            coins_paid <= coins_paid + AMT_W'(1);
            cnt        <= PULSE_LOAD;
            state      <= S_PULSE;
          end else begin
            done      <= 1'b1;
            short_pay <= (remaining != '0);
            state     <= S_DONE;
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            eject_25 <= 1'b0;
            eject_10 <= 1'b0;
            eject_5  <= 1'b0;
            if (GAP_CYCLES > 0) begin
              cnt   <= GAP_LOAD;
              state <= S_GAP;
            end else begin
              state <= S_SELECT;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_SELECT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          change_ready <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench for change_dispenser with gap=2 and gap=0 instances
module tb_change_dispenser;

  localparam int P  = 4;
  localparam int G0 = 2;
  localparam int G1 = 0;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       valid[2];
  logic [7:0] amount[2];
  logic       rdy[2], e25[2], e10[2], e5[2], busy[2], done[2], sp[2];
  logic [7:0] cp[2];

  always #5 clk = ~clk;

  change_dispenser #(.AMT_W(8), .PULSE_CYCLES(P), .GAP_CYCLES(G0)) dut_a (
    .clk(clk), .reset_n(reset_n), .change_valid(valid[0]), .change_amount(amount[0]),
    .change_ready(rdy[0]), .eject_25(e25[0]), .eject_10(e10[0]), .eject_5(e5[0]),
    .busy(busy[0]), .done(done[0]), .short_pay(sp[0]), .coins_paid(cp[0])
  );

  change_dispenser #(.AMT_W(8), .PULSE_CYCLES(P), .GAP_CYCLES(G1)) dut_b (
    .clk(clk), .reset_n(reset_n), .change_valid(valid[1]), .change_amount(amount[1]),
    .change_ready(rdy[1]), .eject_25(e25[1]), .eject_10(e10[1]), .eject_5(e5[1]),
    .busy(busy[1]), .done(done[1]), .short_pay(sp[1]), .coins_paid(cp[1])
  );

  // Expected payout: coin codes (3=25, 2=10, 1=5) two bits each, coin count, short flag.
  typedef struct packed {
    logic [31:0] seq;
    logic [7:0]  n;
    logic        sp;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt[2];

  function automatic void chk(bit ok, string name, int act, int expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic exp_t model(int amt);
    exp_t x;
    int nq, nd, nn, r, k;
    x  = '0;
    nq = amt / 25;
    r  = amt % 25;
    nd = r / 10;
    r  = r % 10;
    nn = r / 5;
    r  = r % 5;
    k  = 0;
    for (int j = 0; j < nq; j++) begin x.seq[2*k +: 2] = 2'd3; k++; end
    for (int j = 0; j < nd; j++) begin x.seq[2*k +: 2] = 2'd2; k++; end
    for (int j = 0; j < nn; j++) begin x.seq[2*k +: 2] = 2'd1; k++; end
    x.n  = 8'(k);
    x.sp = (r != 0);
    return x;
  endfunction

  bit          active[2];
  bit          after_done[2];
  int          run[2], low[2], seg[2], nc[2];
  logic [31:0] seq[2];
  logic [2:0]  prev[2];
  exp_t        cur[2];

  // Monitor: reconstructs pulses/gaps per DUT and scores each payout against the queue.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin : mon
      logic [2:0] e;
      int         g;
      int         want_low;
      e = {e25[i], e10[i], e5[i]};
      g = (i == 0) ? G0 : G1;
      if (!reset_n) begin
        active[i]     = 1'b0;
        after_done[i] = 1'b0;
        run[i]        = 0;
        if (i == 0) q0.delete(); else q1.delete();
      end else begin
        if ($countones(e) > 1) chk(1'b0, "eject_overlap", int'(e), 0);
        if (!active[i]) begin
          if (e != 3'b000) chk(1'b0, "spurious_eject", int'(e), 0);
          if (done[i]) chk(1'b0, "spurious_done", 1, 0);
          if (after_done[i]) begin
            chk(rdy[i] == 1'b1, "ready_after_done", int'(rdy[i]), 1);
            chk(cp[i] == cur[i].n, "coins_held", int'(cp[i]), int'(cur[i].n));
            after_done[i] = 1'b0;
          end
          if (valid[i] && rdy[i]) begin
            if (i == 0 && q0.size() > 0) cur[i] = q0.pop_front();
            else if (i == 1 && q1.size() > 0) cur[i] = q1.pop_front();
            else chk(1'b0, "unexpected_accept", i, -1);
            active[i] = 1'b1;
            run[i]    = 0;
            low[i]    = 0;
            seg[i]    = 0;
            nc[i]     = 0;
            seq[i]    = '0;
          end
        end else begin
          chk(rdy[i] == 1'b0 && busy[i] == 1'b1, "busy_not_ready",
              int'({rdy[i], busy[i]}), 1);
          want_low = (seg[i] == 0) ? 1 : g + 1;
          if (e != 3'b000) begin
            if (run[i] == 0) begin
              chk(low[i] == want_low, "gap_before_pulse", low[i], want_low);
              if (nc[i] < 16) seq[i][2*nc[i] +: 2] = e[2] ? 2'd3 : (e[1] ? 2'd2 : 2'd1);
              nc[i]++;
              seg[i]++;
              low[i] = 0;
              chk(int'(cp[i]) == nc[i], "coins_running", int'(cp[i]), nc[i]);
            end else if (e != prev[i]) begin
              chk(1'b0, "pulse_changed", int'(e), int'(prev[i]));
            end
            run[i]++;
          end else begin
            if (run[i] > 0) chk(run[i] == P, "pulse_len", run[i], P);
            run[i] = 0;
            if (done[i]) begin
              chk(low[i] == want_low, "gap_before_done", low[i], want_low);
              chk(seq[i] == cur[i].seq, "coin_sequence", int'(seq[i]), int'(cur[i].seq));
              chk(nc[i] == int'(cur[i].n), "coin_count", nc[i], int'(cur[i].n));
              chk(cp[i] == cur[i].n, "coins_paid", int'(cp[i]), int'(cur[i].n));
              chk(sp[i] == cur[i].sp, "short_pay", int'(sp[i]), int'(cur[i].sp));
              active[i]     = 1'b0;
              after_done[i] = 1'b1;
              done_cnt[i]++;
            end else begin
              low[i]++;
            end
          end
          prev[i] = e;
        end
      end
    end
  end

  task automatic start_pay(int id, int amt, bit hold);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (!rdy[id] && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk(rdy[id] == 1'b1, "ready_before_req", int'(rdy[id]), 1);
    if (id == 0) q0.push_back(model(amt)); else q1.push_back(model(amt));
    valid[id]  = 1'b1;
    amount[id] = 8'(amt);
    @(posedge clk); #1;
    if (hold) begin
      for (int k = 0; k < 20; k++) begin
        amount[id] = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    valid[id]  = 1'b0;
    amount[id] = 8'($urandom);
  endtask

  task automatic wait_done(int id);
    int c0, t;
    c0 = done_cnt[id];
    t  = 0;
    while (done_cnt[id] == c0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk(done_cnt[id] != c0, "done_timeout", t, 3000);
  endtask

  task automatic pay(int id, int amt);
    start_pay(id, amt, 1'b0);
    wait_done(id);
  endtask

  task automatic check_idle(int id, string name);
    chk({e25[id], e10[id], e5[id]} == 3'b000, {name, "_eject"}, int'({e25[id], e10[id], e5[id]}), 0);
    chk(rdy[id] == 1'b1, {name, "_ready"}, int'(rdy[id]), 1);
    chk(busy[id] == 1'b0 && done[id] == 1'b0 && sp[id] == 1'b0, {name, "_flags"},
        int'({busy[id], done[id], sp[id]}), 0);
    chk(cp[id] == 8'd0, {name, "_coins"}, int'(cp[id]), 0);
  endtask

  initial begin
    int t;
    reset_n   = 1'b0;
    valid[0]  = 1'b0;
    valid[1]  = 1'b0;
    amount[0] = 8'd0;
    amount[1] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "reset_a");
    check_idle(1, "reset_b");
    reset_n = 1'b1;

    pay(0, 40);
    start_pay(0, 100, 1'b1);
    wait_done(0);
    pay(0, 0);
    pay(0, 3);
    pay(0, 255);
    pay(1, 35);
    pay(1, 4);
    pay(1, 255);

    for (int k = 0; k < 30; k++) pay(0, int'($urandom_range(0, 255)));
    for (int k = 0; k < 12; k++) pay(1, int'($urandom_range(0, 255)));

    // Abandon a payout mid-pulse with an asynchronous reset.
    start_pay(0, 100, 1'b0);
    t = 0;
    while (!e25[0] && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk(e25[0] == 1'b1, "reset_setup_pulse", int'(e25[0]), 1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_idle(0, "async_reset");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_idle(0, "after_reset");
    pay(0, 40);
    pay(1, 35);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
